counter_scheduler: RTL
======================

Name: counter_scheduler

Overview:
Round-robin scheduler that shares one `counter` instance (Size-bit, active-high synchronous reset) between several requesters. Each requester asks for a timed run of a given length. The scheduler grants one requester and clears the counter. It lets the counter run until the count reaches the latched target, then pulses `done` to the owner and releases the counter. The scheduler sits beside the counter in the bench/design top, with `ctr_reset` driving the counter's reset and `ctr_count` fed back from its count.

Parameters:
Size, 5, counter width in bits; also the width of each run length.
Requesters, 4, number of requesters (>=2).

Ports:
clock  input  1  single system clock; all state updates on posedge.
reset  input  1  asynchronous, active-low reset.
req  input  Requesters  per-requester run request; level, held until done.
len  input  Requesters*Size  run lengths; requester i uses len[i*Size +: Size]; sampled only at grant.
grant  output  Requesters  one-hot owner of the counter; all-zero when idle.
done  output  Requesters  one-cycle completion pulse to the owner.
busy  output  1  high whenever state != IDLE.
ctr_reset  output  1  drives counter reset; active-high.
ctr_count  input  Size  current counter value.

Behaviour:
- Reset (reset=0, async): state=IDLE, grant=0, done=0, busy=0, ctr_reset=1, target=0, last pointer=Requesters-1 (requester 0 wins first).
- FSM states IDLE, CLEAR, RUN, DONE:
  - IDLE: ctr_reset=1, grant=0.
    - If any req bit is high, choose the first set bit searching from last+1 upward, modulo Requesters.
    - Latch owner and target=len slice of the owner; go to CLEAR.
  - CLEAR: exactly one cycle; ctr_reset=1; grant[owner]=1. The counter clears at the closing edge. Next state is RUN.
  - RUN: ctr_reset=0; grant[owner]=1. Go to DONE on the edge where ctr_count >= target.
    - Use >= (not ==) so an unexpected overshoot still terminates.
  - DONE: exactly one cycle; ctr_reset=1; grant[owner]=1; done[owner]=1.
    - At the closing edge: last=owner, go to IDLE.
- Latency, with req sampled at edge E:
  - grant rises after E and stays high for target+3 cycles.
  - RUN spans target+1 cycles; ctr_count sequences 0..target.
  - done is high in the cycle after edge E+target+2.
- target=0: RUN lasts one cycle (count 0), then DONE; no special casing.
- target=2^Size-1: counter reaches its maximum without wrapping; DONE follows.
- Abort: if req[owner] drops while in CLEAR or RUN, go to IDLE on the next edge.
  - No done pulse; ctr_reset=1; last=owner.
- len changes after the grant are ignored. req changes of non-owners are ignored until IDLE.
- An owner still holding req in IDLE after done is re-arbitrated normally, so other pending requesters win first (fairness).
- Minimum gap: one IDLE cycle between consecutive runs.
- Async reset mid-run: immediate return to the reset values above. No done is issued.
- Outputs are registered (glitch-free). grant is always one-hot or zero. done is never asserted without the matching grant bit.

Test Plan:
1. Reset asserted then released, req=0 → grant=0, done=0, busy=0, ctr_reset=1 held indefinitely.
2. req[0]=1, len0=4 → grant=0001 for 7 cycles; ctr_count 0,1,2,3,4 during RUN; done=0001 pulses once, 6 cycles after grant rises; back to IDLE.
3. req=1111 all held, len=3 each → grants in order 0001,0010,0100,1000,0001; each run 6 cycles plus 1 IDLE gap; each done pulse goes to the matching owner.
4. len1=0 and len1=31 (Size=5) → zero-length run: done 2 cycles after grant. Max run: ctr_count reaches 31 with no wrap; done follows.
5. req[2] dropped mid-RUN (count=2, len=10) → back to IDLE next cycle, no done, ctr_reset=1; the next pending requester after 2 is granted.
6. reset pulsed low mid-RUN → grant, done and busy go to 0 and ctr_reset to 1 immediately. After release, req[0] has priority over req[3].

Source files
------------

// File: rtl/counter_scheduler.sv
// Round-robin owner of one shared counter: grant, clear, run to the latched
// target, then pulse done. All outputs are registered.
module counter_scheduler #(
  parameter int Size       = 5,
  parameter int Requesters = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [Requesters-1:0]      req,
  input  logic [Requesters*Size-1:0] len,
  output logic [Requesters-1:0]      grant,
  output logic [Requesters-1:0]      done,
  output logic                       busy,
  output logic                       ctr_reset,
  input  logic [Size-1:0]            ctr_count
);

  localparam int IW = (Requesters > 1) ? $clog2(Requesters) : 1;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    RUN,
    DONE
  } state_t;

  state_t                state;
  state_t                state_n;
  logic [IW-1:0]         owner;
  logic [IW-1:0]         owner_n;
  logic [IW-1:0]         last;
  logic [IW-1:0]         last_n;
  logic [IW-1:0]         pick;
  logic                  found;
  logic [Size-1:0]       target;
  logic [Size-1:0]       target_n;
  logic [Requesters-1:0] owner_oh;
  logic [Requesters-1:0] grant_n;
  logic [Requesters-1:0] done_n;

  // first requester after the previous owner, wrapping around
  always_comb begin : arb
    found = 1'b0;
    pick  = last;
    for (int k = 1; k <= Requesters; k++) begin
      if (!found && req[(int'(last) + k) % Requesters]) begin
        found = 1'b1;
        pick  = IW'((int'(last) + k) % Requesters);
      end
    end
  end

  always_comb begin : fsm
    state_n  = state;
    owner_n  = owner;
    last_n   = last;
    target_n = target;
    unique case (state)
      IDLE: begin
        if (found) begin
          owner_n  = pick;
          target_n = len[int'(pick)*Size +: Size];
          state_n  = CLEAR;
        end
      end
      CLEAR: begin
        if (!req[owner]) begin
          state_n = IDLE;
          last_n  = owner;
        end else begin
          state_n = RUN;
        end
      end
      RUN: begin
        if (!req[owner]) begin
          state_n = IDLE;
          last_n  = owner;
        end else if (ctr_count >= target) begin
          state_n = DONE;
        end
      end
      DONE: begin
        state_n = IDLE;
        last_n  = owner;
      end
      default: state_n = IDLE;
    endcase
    owner_oh = {{(Requesters-1){1'b0}}, 1'b1} << owner_n;
    grant_n  = (state_n != IDLE) ? owner_oh : '0;
    done_n   = (state_n == DONE) ? owner_oh : '0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      owner     <= '0;
      last      <= IW'(Requesters - 1);
      target    <= '0;
      grant     <= '0;
      done      <= '0;
      busy      <= 1'b0;
      ctr_reset <= 1'b1;
    end else begin
      state     <= state_n;
      owner     <= owner_n;
      last      <= last_n;
      target    <= target_n;
      grant     <= grant_n;
      done      <= done_n;
      busy      <= (state_n != IDLE);
      ctr_reset <= (state_n != RUN);
    end
  end

endmodule
